// File: rtl/mips_branch_unit.sv
// MIPS control-transfer unit: owns the PC, evaluates branches/jumps, and
// steps through the architectural delay slot before redirecting fetch.
module mips_branch_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
  parameter logic [ADDR_W-1:0] HALT_ADDR    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [ADDR_W-1:0] pc,
  output logic              active,
  output logic              link_we,
  output logic [4:0]        link_reg,
  output logic [DATA_W-1:0] link_data
);

  typedef enum logic [1:0] {StRun, StDelay, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;

  logic [5:0]        opcode, funct;
  logic [4:0]        rt_field;
  logic              rs_neg, rs_zero;
  logic [ADDR_W-1:0] pc_plus4, pc_plus8, br_off, br_tgt, jmp_tgt, jr_tgt;
  logic [ADDR_W-1:0] xfer_tgt;
  logic              taken, is_link, link_jalr;

  assign opcode   = instr[31:26];
  assign rt_field = instr[20:16];
  assign funct    = instr[5:0];
  assign rs_neg   = rs_data[DATA_W-1];
  assign rs_zero  = (rs_data == '0);

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign pc_plus8 = pc_q + ADDR_W'(8);
  assign br_off   = {{(ADDR_W-16){instr[15]}}, instr[15:0]};
  assign br_tgt   = pc_plus4 + (br_off << 2);
  // Region bits above bit 27 come from the delay-slot address.
  assign jmp_tgt  = (pc_plus4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({instr[25:0], 2'b00});
  assign jr_tgt   = rs_data[ADDR_W-1:0];

  // Instruction decode: condition, target and link selection.
  always_comb begin
    taken     = 1'b0;
    is_link   = 1'b0;
    link_jalr = 1'b0;
    xfer_tgt  = br_tgt;
    case (opcode)
      6'b000001: begin
        case (rt_field)
          5'b00000: taken = rs_neg;
          5'b00001: taken = !rs_neg;
          5'b10000: begin
            taken   = rs_neg;
            is_link = 1'b1;
          end
          5'b10001: begin
            taken   = !rs_neg;
            is_link = 1'b1;
          end
          default: ;
        endcase
      end
      6'b000100: taken = (rs_data == rt_data);
      6'b000101: taken = (rs_data != rt_data);
      6'b000110: taken = rs_neg || rs_zero;
      6'b000111: taken = !rs_neg && !rs_zero;
      6'b000010: begin
        taken    = 1'b1;
        xfer_tgt = jmp_tgt;
      end
      6'b000011: begin
        taken    = 1'b1;
        is_link  = 1'b1;
        xfer_tgt = jmp_tgt;
      end
      6'b000000: begin
        if (funct == 6'b001000 || funct == 6'b001001) begin
          taken    = 1'b1;
          xfer_tgt = jr_tgt;
        end
        if (funct == 6'b001001) begin
          is_link   = 1'b1;
          link_jalr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StRun;
      pc_q     <= RESET_VECTOR;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    if (clk_enable) begin
      unique case (state_q)
        StRun: begin
          pc_d = pc_plus4;
          if (taken) begin
            target_d = xfer_tgt;
            state_d  = StDelay;
          end
        end
        StDelay: begin
          pc_d    = target_q;
          state_d = (target_q == HALT_ADDR) ? StHalt : StRun;
        end
        StHalt: ;
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc        = pc_q;
    active    = (state_q != StHalt);
    link_we   = clk_enable && !reset && (state_q == StRun) && is_link;
    link_reg  = link_jalr ? instr[15:11] : 5'd31;
    link_data = DATA_W'(pc_plus8);
  end

endmodule

// File: tb/tb_mips_branch_unit.sv
// Bench for mips_branch_unit: directed scenarios plus random instruction
// streams, scored against a behavioural model through an expectation queue.
module tb_mips_branch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] pc;
  logic        active;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_data;

  always #5 clk = ~clk;

  mips_branch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .pc         (pc),
    .active     (active),
    .link_we    (link_we),
    .link_reg   (link_reg),
    .link_data  (link_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic        active;
    logic        lwe;
    logic [4:0]  lreg;
    logic [31:0] ldata;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: current pc, halted flag, and an optional pending redirect.
  logic [31:0] m_pc  = RV;
  bit          m_halt = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_eval(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [31:0] pcv,
                                     output bit tk, output logic [31:0] tgt,
                                     output bit lk, output logic [4:0] lr);
    int signed      srs;
    shortint signed imm;
    logic [31:0]    jt;
    srs = $signed(rs);
    imm = $signed(ins[15:0]);
    tk  = 1'b0;
    lk  = 1'b0;
    lr  = 5'd31;
    tgt = pcv + 32'd4 + 32'(4 * int'(imm));
    jt  = ((pcv + 32'd4) & 32'hF000_0000) | {4'b0, ins[25:0], 2'b00};
    case (ins[31:26])
      6'd1: begin
        case (ins[20:16])
          5'd0:  tk = (srs < 0);
          5'd1:  tk = (srs >= 0);
          5'd16: begin tk = (srs < 0);  lk = 1'b1; end
          5'd17: begin tk = (srs >= 0); lk = 1'b1; end
          default: ;
        endcase
      end
      6'd2: begin tk = 1'b1; tgt = jt; end
      6'd3: begin tk = 1'b1; tgt = jt; lk = 1'b1; end
      6'd4: tk = (rs == rt);
      6'd5: tk = (rs != rt);
      6'd6: tk = (srs <= 0);
      6'd7: tk = (srs > 0);
      6'd0: begin
        if (ins[5:0] == 6'd8) begin tk = 1'b1; tgt = rs; end
        if (ins[5:0] == 6'd9) begin tk = 1'b1; tgt = rs; lk = 1'b1; lr = ins[15:11]; end
      end
      default: ;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input logic en);
    bit          tk, lk;
    logic [31:0] tg;
    logic [4:0]  lr;
    exp_t        e;
    instr      = ins;
    rs_data    = rs;
    rt_data    = rt;
    clk_enable = en;
    model_eval(ins, rs, rt, m_pc, tk, tg, lk, lr);
    e.pc     = m_pc;
    e.active = !m_halt;
    e.lwe    = en && !m_halt && !m_pend && lk;
    e.lreg   = lr;
    e.ldata  = m_pc + 32'd8;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    bit          tk, lk;
    logic [31:0] tg;
    logic [4:0]  lr;
    logic [31:0] n_pc, n_tgt;
    bit          n_halt, n_pend;
    model_eval(instr, rs_data, rt_data, m_pc, tk, tg, lk, lr);
    n_pc = m_pc; n_tgt = m_tgt; n_halt = m_halt; n_pend = m_pend;
    if (clk_enable && !m_halt) begin
      if (m_pend) begin
        n_pc   = m_tgt;
        n_pend = 1'b0;
        n_halt = (m_tgt == 32'd0);
      end else begin
        n_pc = m_pc + 32'd4;
        if (tk) begin
          n_pend = 1'b1;
          n_tgt  = tg;
        end
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_tgt = n_tgt; m_halt = n_halt; m_pend = n_pend;
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input logic en);
    drive(ins, rs, rt, en);
    tick();
  endtask

  // Reset is raised between edges so its effect is seen without any clock.
  task automatic do_reset();
    instr = 32'h0C000000;
    clk_enable = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_active", {31'b0, active}, 32'd1);
    chk("rst_link_we", {31'b0, link_we}, 32'd0);
    reset = 1'b0;
    instr = '0;
    m_pc = RV; m_halt = 1'b0; m_pend = 1'b0; m_tgt = '0;
  endtask

  // Scoreboard monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("mon_pc", pc, e.pc);
      chk("mon_active", {31'b0, active}, {31'b0, e.active});
      chk("mon_link_we", {31'b0, link_we}, {31'b0, e.lwe});
      if (e.lwe) begin
        chk("mon_link_reg", {27'b0, link_reg}, {27'b0, e.lreg});
        chk("mon_link_data", link_data, e.ldata);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  rtsel;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        case ($urandom_range(0, 3))
          0: rtsel = 5'd0;
          1: rtsel = 5'd1;
          2: rtsel = 5'd16;
          default: rtsel = 5'd17;
        endcase
        r = {6'd1, r[25:21], rtsel, r[15:0]};
      end
      1, 2, 3, 4: r = {3'b000, 1'b1, r[27:26], r[25:0]};
      5: r = {5'b00001, r[26], r[25:0]};
      6: r = {6'd0, r[25:21], 5'd0, r[15:11], 5'd0, 5'b00100, r[0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ri, rrs, rrt;
    @(posedge clk);
    #1;
    do_reset();

    // Straight-line fetch.
    repeat (3) step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("nop3_pc", pc, 32'hBFC0000C);

    // BLTZ taken from BFC00008.
    do_reset();
    repeat (2) step(32'h0, 32'h0, 32'h0, 1'b1);
    step(32'h04000080, 32'hF0000000, 32'h0, 1'b1);
    chk("bltz_slot_pc", pc, 32'hBFC0000C);
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("bltz_tgt_pc", pc, 32'hBFC0020C);

    // BLTZ not taken for zero and positive rs.
    step(32'h04000080, 32'h0, 32'h0, 1'b1);
    chk("bltz_nt0_pc", pc, 32'hBFC00210);
    step(32'h04000080, 32'h14, 32'h0, 1'b1);
    chk("bltz_ntp_pc", pc, 32'hBFC00214);

    // BGEZAL at BFC00010.
    do_reset();
    repeat (4) step(32'h0, 32'h0, 32'h0, 1'b1);
    drive(32'h04110004, 32'h5, 32'h0, 1'b1);
    #1;
    chk("bgezal_we", {31'b0, link_we}, 32'd1);
    chk("bgezal_reg", {27'b0, link_reg}, 32'd31);
    chk("bgezal_data", link_data, 32'hBFC00018);
    tick();
    chk("bgezal_slot_pc", pc, 32'hBFC00014);
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("bgezal_tgt_pc", pc, 32'hBFC00024);

    // JR to HALT_ADDR with a JAL in the delay slot.
    do_reset();
    step(32'h00000008, 32'h0, 32'h0, 1'b1);
    chk("jr_slot_pc", pc, 32'hBFC00004);
    drive(32'h0C000010, 32'h0, 32'h0, 1'b1);
    #1;
    chk("slot_no_link", {31'b0, link_we}, 32'd0);
    tick();
    chk("halt_pc", pc, 32'h0);
    chk("halt_active", {31'b0, active}, 32'd0);
    for (int i = 0; i < 10; i++) step(rand_instr(), $urandom, $urandom, 1'b1);
    chk("halt_hold_pc", pc, 32'h0);

    // Reset in DELAY drops the pending jump.
    do_reset();
    step(32'h08000100, 32'h0, 32'h0, 1'b1);
    do_reset();
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("rst_delay_pc", pc, 32'hBFC00004);

    // clk_enable low freezes everything, even across a link branch.
    repeat (3) step(32'h04110004, 32'h5, 32'h0, 1'b0);
    chk("ce0_pc", pc, 32'hBFC00004);
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("ce1_pc", pc, 32'hBFC00008);

    // Branch target wrap-around near the top of the address space.
    do_reset();
    step(32'h00000008, 32'hFFFFFFF8, 32'h0, 1'b1);
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("jr_hi_pc", pc, 32'hFFFFFFF8);
    step(32'h10000010, 32'h7, 32'h7, 1'b1);
    chk("beq_slot_pc", pc, 32'hFFFFFFFC);
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("beq_wrap_pc", pc, 32'h0000003C);

    // Unaligned JALR target, link to rd=5.
    do_reset();
    step(32'h00002809, 32'h00001003, 32'h0, 1'b1);
    step(32'h0, 32'h0, 32'h0, 1'b1);
    chk("jalr_unal_pc", pc, 32'h00001003);

    // Random instruction stream.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_halt || $urandom_range(0, 59) == 0) do_reset();
      ri  = rand_instr();
      rrt = $urandom;
      case ($urandom_range(0, 3))
        0: rrs = 32'h0;
        1: rrs = $urandom;
        2: rrs = $urandom | 32'h8000_0000;
        default: rrs = rrt;
      endcase
      step(ri, rrs, rrt, ($urandom_range(0, 9) != 0));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_branch_unit.md
MIPS_BRANCH_UNIT -- requirements
Module: mips_branch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: program-counter and target width in bits.
REQ-002 Parameter DATA_W, default 32: register-operand width in bits, DATA_W >= ADDR_W.
REQ-003 Parameter RESET_VECTOR, default 32'hBFC00000: PC value loaded on reset.
REQ-004 Parameter HALT_ADDR, default 0: jump/branch target that halts the CPU.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; forces reset state immediately, regardless of clk.
REQ-007 clk_enable  in  1  when 0, no state changes (PC, FSM, latched target all frozen).
REQ-008 instr  in  32  instruction currently fetched at pc.
REQ-009 rs_data  in  DATA_W  value of register rs for instr.
REQ-010 rt_data  in  DATA_W  value of register rt for instr.
REQ-011 pc  out  ADDR_W  current instruction address (drives instr_address).
REQ-012 active  out  1  high while executing; low once halted.
REQ-013 link_we  out  1  combinational; high when instr is a link instruction in RUN state with clk_enable=1.
REQ-014 link_reg  out  5  combinational; 31 for BLTZAL/BGEZAL/JAL, instr[15:11] for JALR.
REQ-015 link_data  out  DATA_W  combinational; pc+8, zero-extended.

Function
REQ-016 FSM states SHALL be RUN, DELAY, HALT; reset state RUN.
REQ-017 Decoded control transfers: REGIMM (opcode 000001) rt=00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL; opcode 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ, 000010 J, 000011 JAL; opcode 000000 funct 001000 JR, funct 001001 JALR.
REQ-018 Conditions: signed comparison of rs_data against 0 for BLTZ/BGEZ/BLEZ/BGTZ families; BEQ/BNE compare rs_data and rt_data over full DATA_W.
REQ-019 Branch target = (pc+4) + (sign-extended instr[15:0] << 2), modulo 2^ADDR_W (wrap-around, no error).
REQ-020 J/JAL target = {(pc+4)[ADDR_W-1:28], instr[25:0], 2'b00}; JR/JALR target = rs_data[ADDR_W-1:0].
REQ-021 RUN, taken transfer: latch target, pc <= pc+4, go DELAY.
REQ-022 RUN, not taken or non-transfer instruction: pc <= pc+4, stay RUN.
REQ-023 Link instructions assert link_we whether or not the condition is taken.
REQ-024 DELAY: pc <= latched target; control-transfer instructions in the delay slot are not evaluated and do not assert link_we; if target == HALT_ADDR go HALT, else RUN.
REQ-025 HALT: pc holds HALT_ADDR, active=0, link_we=0; only reset exits.
REQ-026 Unaligned JR/JALR targets (low bits nonzero) are used as-is; no exception.
REQ-027 clk_enable=0 in any state freezes pc, state and latched target for that edge.

Reset
REQ-028 On reset assertion: pc=RESET_VECTOR, state=RUN, active=1, latched target=0, link_we=0, effective immediately.
REQ-029 Reset asserted in DELAY discards the pending target; first post-reset edge fetches RESET_VECTOR+4.

Verification
REQ-030 Reset pulse -> pc=BFC00000, active=1; three non-branch edges -> pc=BFC0000C.
REQ-031 At pc=BFC00008, BLTZ rs_data=F0000000, imm=0x0080 -> next pc=BFC0000C, following edge pc=BFC0020C.
REQ-032 BLTZ rs_data=0 or rs_data=00000014, imm=0x0080 -> pc advances by 4 each edge (BFC00088 -> BFC0008C -> BFC00090).
REQ-033 BGEZAL at pc=BFC00010, rs_data=00000005 -> link_we=1, link_reg=31, link_data=BFC00018; then taken as REQ-021.
REQ-034 JR with rs_data=0 -> delay slot at pc+4, then pc=0, active=0, pc frozen across 10 further edges.
REQ-035 Reset asserted mid-DELAY, and clk_enable=0 for 3 edges during RUN -> pc returns to BFC00000 / pc unchanged, respectively.
